// File: rtl/tc_product_rescale.sv
// Rescales the signed multiplier product by an arithmetic right shift, saturates it
// into OUT_WIDTH, and counts overflows. TC_PRODUCT_RESCALE_ROUND_EN selects round-half-up.
module tc_product_rescale #(
  parameter int IN_WIDTH  = 32,
  parameter int SHIFT     = 14,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_ovf,
  output logic [CNT_WIDTH-1:0]        ovf_count
);

`ifdef TC_PRODUCT_RESCALE_ROUND_EN
  localparam int S1W = IN_WIDTH + 1;
  localparam logic signed [S1W-1:0] RND_V = S1W'(1'b1) << (SHIFT - 1);
`else
  localparam int S1W = IN_WIDTH;
`endif

  localparam logic signed [S1W-1:0] MAX_V = {{(S1W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [S1W-1:0] MIN_V = {{(S1W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic                        s1_valid_q, s1_valid_d;
  logic signed [S1W-1:0]       s1_data_q, s1_data_d;
  logic                        s2_valid_q, s2_valid_d;
  logic signed [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                        s2_ovf_q, s2_ovf_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

  logic                        s1_load_s, s2_load_s;
  logic signed [S1W-1:0]       s1_in_s, shift_s;
  logic signed [OUT_WIDTH-1:0] sat_s;
  logic                        sat_ovf_s;

  // Next-state logic for both pipeline stages and the overflow counter.
  always_comb begin
    s2_load_s = !s2_valid_q || out_ready;
    s1_load_s = !s1_valid_q || s2_load_s;

`ifdef TC_PRODUCT_RESCALE_ROUND_EN
    s1_in_s = S1W'(in_data) + RND_V;
`else
    s1_in_s = S1W'(in_data);
`endif

    shift_s = s1_data_q >>> SHIFT;
    if (shift_s > MAX_V) begin
      sat_s     = MAX_V[OUT_WIDTH-1:0];
      sat_ovf_s = 1'b1;
    end else if (shift_s < MIN_V) begin
      sat_s     = MIN_V[OUT_WIDTH-1:0];
      sat_ovf_s = 1'b1;
    end else begin
      sat_s     = shift_s[OUT_WIDTH-1:0];
      sat_ovf_s = 1'b0;
    end

    if (s1_load_s) begin
      s1_valid_d = in_valid;
      s1_data_d  = s1_in_s;
    end else begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
    end

    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = sat_s;
      s2_ovf_d   = sat_ovf_s;
    end else begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_ovf_d   = s2_ovf_q;
    end

    // Counter sticks at all-ones rather than wrapping.
    if (s2_valid_q && out_ready && s2_ovf_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset; reset drops any in-flight data.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = s1_load_s;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_ovf   = s2_ovf_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_tc_product_rescale.sv
// Scoreboard bench for tc_product_rescale: random and directed stimulus against a
// floor/round-then-clamp reference model; a second instance exercises a 2-bit counter.
module tb_tc_product_rescale;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               ap_rst;
  logic signed [31:0] in_data;
  logic               in_valid, in_ready;
  logic [15:0]        out_data;
  logic               out_valid, out_ready, out_ovf;
  logic [15:0]        ovf_count;

  logic signed [31:0] c_in_data;
  logic               c_in_valid, c_in_ready;
  logic [15:0]        c_out_data;
  logic               c_out_valid, c_out_ovf;
  logic               c_out_ready;
  logic [1:0]         c_ovf_count;

  tc_product_rescale dut (
    .ap_clk(clk), .ap_rst(ap_rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ovf(out_ovf), .ovf_count(ovf_count)
  );

  tc_product_rescale #(.CNT_WIDTH(2)) dut_c (
    .ap_clk(clk), .ap_rst(ap_rst),
    .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_ovf(c_out_ovf), .ovf_count(c_ovf_count)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic        hold_v = 1'b0;
  logic [15:0] hold_d;
  logic        hold_o;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scale by 2^14 with floor (optionally after adding half), then clamp to int16.
  function automatic exp_t model(input logic signed [31:0] x);
    longint v, q, dv;
    exp_t   e;
    dv = 64'sd16384;
    v  = longint'(x);
`ifdef TC_PRODUCT_RESCALE_ROUND_EN
    v = v + dv / 64'sd2;
`endif
    q = v / dv;
    if ((v % dv != 64'sd0) && (v < 64'sd0)) q = q - 64'sd1;
    if (q > 64'sd32767) begin
      e.d = 16'h7fff; e.o = 1'b1;
    end else if (q < -64'sd32768) begin
      e.d = 16'h8000; e.o = 1'b1;
    end else begin
      e.d = q[15:0]; e.o = 1'b0;
    end
    return e;
  endfunction

  // Stimulus side of the scoreboard: record expected result of every accepted input.
  always @(negedge clk) begin
    if (ap_rst) sb.delete();
    else if (in_valid && in_ready) sb.push_back(model(in_data));
  end

  // Monitor: compare every delivered output, hold stability and the overflow count.
  always @(negedge clk) begin
    exp_t e;
    if (ap_rst) begin
      exp_cnt = 0;
      hold_v  = 1'b0;
    end else begin
      check("ovf_count", ovf_count, exp_cnt);
      if (hold_v && out_valid) begin
        check("hold_data", out_data, hold_d);
        check("hold_ovf", out_ovf, hold_o);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.d);
          check("out_ovf", out_ovf, e.o);
          if (e.o && exp_cnt < 65535) exp_cnt = exp_cnt + 1;
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_o = out_ovf;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [31:0] v);
    int n;
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic signed [31:0] rand_data();
    case ($urandom_range(0, 4))
      0: rand_data = $urandom;
      1: rand_data = int'($urandom_range(0, 1048576)) - 524288;
      2: rand_data = 536870912 + int'($urandom_range(0, 65535)) - 32768;
      3: rand_data = -536870912 + int'($urandom_range(0, 65535)) - 32768;
      4: rand_data = (int'($urandom_range(0, 4000)) - 2000) * 16384 + 8192;
      default: rand_data = 0;
    endcase
  endfunction

  initial begin
    int k, acc, n;
    ap_rst = 1'b1; in_valid = 1'b0; in_data = 0; out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = 0; c_out_ready = 1'b1;
    repeat (3) step();
    ap_rst = 1'b0;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_ovf_count", ovf_count, 0);
    check("rst_in_ready", in_ready, 1);

    // Latency: output visible exactly two cycles after the transfer cycle.
    in_valid = 1'b1; in_data = 16384;
    step();
    in_valid = 1'b0;
    check("lat_early", out_valid, 0);
    step();
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 1);
    check("lat_ovf", out_ovf, 0);
    step();

    send(24576);
    send(-24576);
    send(536870912);
    send(-536870912);
    send(-536887296);
    repeat (4) step();
    check("sat_count", ovf_count, 2);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 5 * 16384;
    step();
    in_data = 6 * 16384;
    step();
    in_valid = 1'b0;
    check("full_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", ovf_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(7 * 16384);
    check("post_rst_early", out_valid, 0);
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 7);
    step();

    // Backpressure: only two accepted while the consumer stalls.
    out_ready = 1'b0; k = 1; acc = 0;
    repeat (5) begin
      in_valid = 1'b1; in_data = k * 16384;
      if (in_ready) begin acc++; k++; end
      step();
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_data", out_data, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (k <= 4);
      in_data  = k * 16384;
      check("bp_no_gap", out_valid, 1);
      if (in_valid && in_ready) k++;
      step();
    end
    in_valid = 1'b0;
    check("bp_all_sent", k, 5);
    repeat (3) step();

    // Random traffic with random backpressure.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_data();
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_empty", sb.size(), 0);

    // 2-bit overflow counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      c_in_valid = 1'b1; c_in_data = 536870912 + i;
      step();
      c_in_valid = 1'b0;
      n = 0;
      while (!c_out_valid && n < 10) begin
        step();
        n++;
      end
      check("cnt_out_valid", c_out_valid, 1);
      check("cnt_out_ovf", c_out_ovf, 1);
      step();
      check("cnt_sat", c_ovf_count, (i + 1 > 3) ? 3 : i + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/tc_product_rescale.md
Name: tc_product_rescale

Overview:
- Downstream consumer of the TrackletCalculator signed 17x15 multiplier.
- Takes the 32-bit signed product and arithmetic-right-shifts it by a fixed number of bits back to the working fixed-point grid.
- Saturates the result into the output width and flags range overflow.
- Two-stage valid/ready pipeline with bubble collapse; also keeps a saturating count of overflowed products for monitoring.

Parameters:
- IN_WIDTH, 32: signed product width.
- SHIFT, 14: arithmetic right shift applied to the product (1..IN_WIDTH-2).
- OUT_WIDTH, 16: signed output width after saturation (2..IN_WIDTH-SHIFT+1).
- CNT_WIDTH, 16: width of the overflow counter.

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- in_data  in  IN_WIDTH  signed product from multiplier.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  OUT_WIDTH  signed rescaled, saturated result.
- out_valid  out  1  out_data/out_ovf valid.
- out_ready  in  1  consumer accepts this cycle.
- out_ovf  out  1  result was saturated.
- ovf_count  out  CNT_WIDTH  number of saturated results delivered since reset.

Behaviour:
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Stage 1 (S1):
  - Registers in_data, plus the rounding addend when ROUND is enabled.
  - Intermediate is IN_WIDTH+1 bits, so the rounding add never wraps.
- Stage 2 (S2):
  - Shifts S1 arithmetically right by SHIFT.
  - Compares against [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Clamps to the nearest bound if outside and sets out_ovf=1; otherwise passes the low OUT_WIDTH bits with out_ovf=0.
- Pipeline control:
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load (combinational from out_ready; no registered skid).
  - S2 loads from S1 when s2_load; s2_valid takes s1_valid.
  - S1 loads from the input when s1_load; s1_valid takes in_valid.
  - Held stages keep data and valid unchanged.
- Latency and throughput:
  - Latency 2 cycles from input transfer to out_valid, with out_ready held high.
  - Throughput 1 result per cycle.
  - Bubbles collapse: an empty S2 loads even while out_ready=0.
- Ordering: strictly in order; no drops, no duplicates.
- out_data, out_ovf:
  - Change only when S2 loads.
  - Stable while out_valid && !out_ready.
- ovf_count:
  - Increments on each output transfer with out_ovf=1.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
- Reset:
  - Values: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_ovf=0, ovf_count=0.
  - in_ready reads 1 in the cycle after reset deasserts; it is don't-care while ap_rst=1.
  - Reset mid-stream discards both stages; any in-flight data is lost.
- Simultaneous input and output transfers in the same cycle are legal and sustain full rate.

Optional Feature:
- Macro: TC_PRODUCT_RESCALE_ROUND_EN.
- Defined: round half up. S1 adds 2^(SHIFT-1) before the shift, so ties round toward +infinity.
- Undefined: truncation (floor). No addend is added; the S1 register is IN_WIDTH wide. Datapath latency is unchanged (2 cycles).

Test Plan:
- Exact multiple, defaults: in_data=16384, out_ready=1 -> out_data=1, out_ovf=0, out_valid exactly 2 cycles after the input transfer.
- Rounding on 24576 then -24576:
  - With ROUND_EN -> 2 then -1.
  - Without -> 1 then -2.
- Saturation:
  - in_data=536870912 -> out_data=32767, out_ovf=1.
  - in_data=-536870912 -> -32768, out_ovf=0.
  - in_data=-536887296 -> -32768, out_ovf=1.
  - After all three transfers, ovf_count=2.
- Backpressure:
  - Stream 1,2,3,4 (x16384) continuously with out_ready=0 for 5 cycles -> in_ready falls after 2 accepted.
  - out_data holds 1 stable.
  - After release, outputs arrive 1,2,3,4 in order with no gaps or loss.
- Reset mid-stream: assert ap_rst for 1 cycle with both stages full -> next cycle out_valid=0, ovf_count=0; the next accepted input emerges 2 cycles later as the first output.
- Counter saturation, CNT_WIDTH=2: 5 overflowing transfers -> ovf_count reads 1, 2, 3, 3, 3.
